// File: rtl/fifo_word_reader.sv
// -----------------------------------------------------------------------------
// fifo_word_reader
//
// Read-side drain engine for the byte FIFO. Pops bytes whenever the FIFO is
// non-empty, packs them little-endian into BYTES-wide words and presents each
// word on a valid/ready stream. A flush request emits a partially filled word
// early; unfilled lanes of such a word read 0.
//
// Ports
//   rd_clk      in   clock, all logic on the rising edge
//   reset_n     in   synchronous active-low reset
//   empty       in   FIFO empty flag (rd_clk domain)
//   fifo_data   in   FIFO data_out, valid whenever empty=0
//   rd          out  FIFO pop strobe, one byte consumed per edge with rd=1
//   flush       in   request early emission of a partial word
//   word_out    out  packed word, byte 0 in [7:0]
//   word_valid  out  word_out / byte_cnt valid
//   word_ready  in   downstream accepts when word_valid && word_ready
//   byte_cnt    out  number of valid bytes in word_out (1..BYTES)
//   word_count  out  count of accepted words, wraps to 0
// -----------------------------------------------------------------------------
module fifo_word_reader #(
    parameter int BYTES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 rd_clk,
    input  logic                 reset_n,
    input  logic                 empty,
    input  logic [7:0]           fifo_data,
    output logic                 rd,
    input  logic                 flush,
    output logic [8*BYTES-1:0]   word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [3:0]           byte_cnt,
    output logic [CNT_W-1:0]     word_count
);

    localparam int IDX_W = $clog2(BYTES);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [8*BYTES-1:0] word_q, word_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pop;

    // Pop strobe is combinational so a byte is taken on the very edge the
    // FIFO shows it; gated by reset_n so nothing is consumed while in reset.
    assign rd  = reset_n && (state_q == FILL) && !empty;
    assign pop = rd;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        count_d = count_q;

        case (state_q)
            FILL: begin
                if (pop) begin
                    word_d[{idx_q, 3'b000} +: 8] = fifo_data;
                end
                if (pop && (idx_q == IDX_W'(BYTES - 1))) begin
                    state_d = HOLD;
                    cnt_d   = 4'(BYTES);
                    idx_d   = '0;
                end else if (flush && ((idx_q != '0) || pop)) begin
                    // A byte popped on the flush edge belongs to this word.
                    state_d = HOLD;
                    cnt_d   = 4'(idx_q) + 4'(pop);
                    idx_d   = '0;
                end else if (pop) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HOLD: begin
                // Handshake edge is the single bubble: rd is low in HOLD, so
                // the first pop of the next word happens one edge later.
                if (word_ready) begin
                    state_d = FILL;
                    word_d  = '0;
                    cnt_d   = '0;
                    count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    // Clearing word_q on reset and on every handshake is what makes the
    // unfilled lanes of a flushed word read 0.
    always_ff @(posedge rd_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == HOLD);
    assign byte_cnt   = cnt_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_reader
//
// Directed bench for fifo_word_reader (BYTES=4, CNT_W=16). A byte queue stands
// in for the FIFO: empty/fifo_data are driven from its head on the falling
// edge and the head is popped when rd was high across the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_word_reader;

    logic        rd_clk = 1'b0;
    logic        reset_n;
    logic        empty;
    logic [7:0]  fifo_data;
    logic        rd;
    logic        flush;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  byte_cnt;
    logic [15:0] word_count;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  fifo_q[$];
    logic        last_rd;
    logic [31:0] held_word;

    fifo_word_reader #(.BYTES(4), .CNT_W(16)) dut (
        .rd_clk     (rd_clk),
        .reset_n    (reset_n),
        .empty      (empty),
        .fifo_data  (fifo_data),
        .rd         (rd),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_cnt   (byte_cnt),
        .word_count (word_count)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: called on a falling edge, returns on the next falling edge.
    // last_rd holds the rd level seen across the rising edge in between.
    task automatic step();
        empty     = (fifo_q.size() == 0);
        fifo_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
        #1;
        last_rd = rd;
        @(posedge rd_clk);
        if (last_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        @(negedge rd_clk);
        empty     = (fifo_q.size() == 0);
        fifo_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        fifo_q.push_back(b0);
        fifo_q.push_back(b1);
        fifo_q.push_back(b2);
        fifo_q.push_back(b3);
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        empty      = 1'b1;
        fifo_data  = 8'h00;
        @(negedge rd_clk);

        // Reset with a non-empty FIFO: nothing popped, outputs cleared.
        fifo_q.push_back(8'h99);
        step();
        check("rst_rd_0", 64'(last_rd), 64'd0);
        step();
        check("rst_rd_1", 64'(last_rd), 64'd0);
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_word", 64'(word_out), 64'd0);
        check("rst_bcnt", 64'(byte_cnt), 64'd0);
        check("rst_wcnt", 64'(word_count), 64'd0);
        fifo_q.delete();
        reset_n = 1'b1;
        step();
        check("idle_valid", 64'(word_valid), 64'd0);

        // Full word 11,22,33,44 with ready already high.
        word_ready = 1'b1;
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("w1_rd%0d", i), 64'(last_rd), 64'd1);
        end
        check("w1_valid", 64'(word_valid), 64'd1);
        check("w1_word", 64'(word_out), 64'h44332211);
        check("w1_bcnt", 64'(byte_cnt), 64'd4);
        step();
        check("w1_hs_rd", 64'(last_rd), 64'd0);
        check("w1_after_valid", 64'(word_valid), 64'd0);
        check("w1_after_word", 64'(word_out), 64'd0);
        check("w1_wcnt", 64'(word_count), 64'd1);

        // Backpressure: 8 bytes queued, ready low.
        word_ready = 1'b0;
        push4(8'h01, 8'h02, 8'h03, 8'h04);
        push4(8'h05, 8'h06, 8'h07, 8'h08);
        for (int i = 0; i < 4; i++) step();
        check("bp_valid", 64'(word_valid), 64'd1);
        check("bp_word", 64'(word_out), 64'h04030201);
        held_word = 32'h04030201;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("bp_hold_rd%0d", i), 64'(last_rd), 64'd0);
            check($sformatf("bp_hold_w%0d", i),
                  64'({word_valid, byte_cnt, word_out}),
                  64'({1'b1, 4'd4, held_word}));
        end
        check("bp_fifo_left", 64'(fifo_q.size()), 64'd4);
        word_ready = 1'b1;
        step();
        check("bp_hs_rd", 64'(last_rd), 64'd0);
        check("bp_wcnt", 64'(word_count), 64'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("bp2_rd%0d", i), 64'(last_rd), 64'd1);
        end
        check("bp2_word", 64'(word_out), 64'h08070605);
        step();
        check("bp2_wcnt", 64'(word_count), 64'd3);

        // Flush after two pops with FIFO drained.
        word_ready = 1'b0;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        step();
        step();
        check("fl2_noval", 64'(word_valid), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl2_valid", 64'(word_valid), 64'd1);
        check("fl2_word", 64'(word_out), 64'h0000BBAA);
        check("fl2_bcnt", 64'(byte_cnt), 64'd2);
        word_ready = 1'b1;
        step();
        check("fl2_wcnt", 64'(word_count), 64'd4);

        // Flush coincident with the third pop.
        word_ready = 1'b0;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        fifo_q.push_back(8'hCC);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl3_rd", 64'(last_rd), 64'd1);
        check("fl3_word", 64'(word_out), 64'h00CCBBAA);
        check("fl3_bcnt", 64'(byte_cnt), 64'd3);
        word_ready = 1'b1;
        step();
        check("fl3_wcnt", 64'(word_count), 64'd5);

        // Flush with nothing accumulated produces no word.
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        check("fl0_valid", 64'(word_valid), 64'd0);
        check("fl0_wcnt", 64'(word_count), 64'd5);

        // Reset after two pops discards the partial bytes.
        word_ready = 1'b0;
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h66);
        step();
        step();
        reset_n = 1'b0;
        step();
        check("mid_rst_word", 64'(word_out), 64'd0);
        check("mid_rst_wcnt", 64'(word_count), 64'd0);
        reset_n = 1'b1;
        push4(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        for (int i = 0; i < 4; i++) step();
        check("mid_valid", 64'(word_valid), 64'd1);
        check("mid_word", 64'(word_out), 64'hF0DEBC9A);
        check("mid_bcnt", 64'(byte_cnt), 64'd4);
        word_ready = 1'b1;
        step();
        check("mid_wcnt", 64'(word_count), 64'd1);

        // Counter wrap: hold the forced value across an idle edge so the
        // register itself captures 16'hFFFF before the force is released.
        word_ready = 1'b0;
        force dut.count_q = 16'hFFFF;
        step();
        release dut.count_q;
        step();
        check("wrap_pre", 64'(word_count), 64'hFFFF);
        push4(8'h10, 8'h20, 8'h30, 8'h40);
        for (int i = 0; i < 4; i++) step();
        check("wrap_word", 64'(word_out), 64'h40302010);
        word_ready = 1'b1;
        step();
        check("wrap_post", 64'(word_count), 64'h0000);
        check("wrap_valid", 64'(word_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
